// File: rtl/icache_responder.sv
// icache_responder: direct-mapped, one-word-per-line instruction cache with single-word refill.
module icache_responder #(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        iflush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int TAG_W = 30 - IDX_W;
    typedef enum logic {IDLE, MISS} state_t;
    state_t state_q, state_d;
    logic [SETS-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [SETS];
    logic [31:0] data_q [SETS];
    logic [31:0] miss_addr_q, miss_addr_d, hit_count_q, hit_count_d, miss_count_q, miss_count_d;
    logic [IDX_W-1:0] idx, fidx;
    logic [TAG_W-1:0] tag;
    logic miss, fill;
    always_comb begin
        idx          = imemaddr[IDX_W+1:2];
        tag          = imemaddr[31:IDX_W+2];
        fidx         = miss_addr_q[IDX_W+1:2];
        ihit         = state_q == IDLE && imemREN && valid_q[idx] && tag_q[idx] == tag && !iflush;
        miss         = state_q == IDLE && imemREN && !ihit && !iflush;
        fill         = state_q == MISS && !iwait;
        imemload     = state_q == IDLE ? data_q[idx] : 32'h0;
        iREN         = state_q == MISS;
        iaddr        = state_q == MISS ? miss_addr_q : 32'h0;
        state_d      = miss ? MISS : fill ? IDLE : state_q;
        miss_addr_d  = miss ? {imemaddr[31:2], 2'b00} : miss_addr_q;
        hit_count_d  = hit_count_q + {31'b0, ihit};
        miss_count_d = miss_count_q + {31'b0, miss};
        hit_count    = hit_count_q;
        miss_count   = miss_count_q;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            miss_addr_q  <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            for (int i = 0; i < SETS; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            // flush wins over a same-cycle fill: data/tag land but the line stays invalid
            if (iflush) valid_q <= '0;
            else if (fill) valid_q[fidx] <= 1'b1;
            if (fill) begin
                tag_q[fidx]  <= miss_addr_q[31:IDX_W+2];
                data_q[fidx] <= iload;
            end
        end
    end
endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder: directed checks of hit/miss timing, conflicts, flush and reset.
module tb_icache_responder;
    logic clk = 0, rst = 1;
    logic imemREN = 0, iflush = 0, iwait = 1;
    logic [31:0] imemaddr = 0, iload = 0;
    logic ihit, iREN;
    logic [31:0] imemload, iaddr, hit_count, miss_count;
    int checks = 0, failures = 0;

    icache_responder dut (
        .CLK(clk), .RST(rst), .imemREN(imemREN), .imemaddr(imemaddr), .iflush(iflush),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr), .iwait(iwait),
        .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic do_miss(input logic [31:0] a, input int n, input logic [31:0] d);
        @(negedge clk); imemREN = 1; imemaddr = a; iwait = 1; iflush = 0; #1;
        checks++; if (ihit !== 1'b0) begin failures++; $display("FAIL miss_c0_ihit a=%h got=%b exp=0", a, ihit); end
        checks++; if (iREN !== 1'b0) begin failures++; $display("FAIL miss_c0_iren a=%h got=%b exp=0", a, iREN); end
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            checks++; if (iREN !== 1'b1 || iaddr !== {a[31:2], 2'b00} || ihit !== 1'b0) begin
                failures++; $display("FAIL miss_wait a=%h iREN=%b iaddr=%h ihit=%b exp 1/%h/0", a, iREN, iaddr, ihit, {a[31:2], 2'b00});
            end
        end
        @(negedge clk); iwait = 0; iload = d; #1;
        checks++; if (iREN !== 1'b1 || iaddr !== {a[31:2], 2'b00}) begin
            failures++; $display("FAIL miss_fill a=%h iREN=%b iaddr=%h exp 1/%h", a, iREN, iaddr, {a[31:2], 2'b00});
        end
        @(negedge clk); iwait = 1; iload = 0; #1;
        checks++; if (ihit !== 1'b1 || imemload !== d || iREN !== 1'b0) begin
            failures++; $display("FAIL miss_done a=%h ihit=%b imemload=%h iREN=%b exp 1/%h/0", a, ihit, imemload, iREN, d);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (ihit !== 0 || iREN !== 0 || iaddr !== 0 || imemload !== 0) begin
            failures++; $display("FAIL reset_out ihit=%b iREN=%b iaddr=%h imemload=%h exp all 0", ihit, iREN, iaddr, imemload);
        end
        checks++; if (hit_count !== 0 || miss_count !== 0) begin
            failures++; $display("FAIL reset_cnt hit=%0d miss=%0d exp 0/0", hit_count, miss_count);
        end
        rst = 0;
    endtask

    task automatic test_miss;
        do_miss(32'h40, 3, 32'h2402_0005);
        checks++; if (miss_count !== 1) begin failures++; $display("FAIL first_miss_count got=%0d exp=1", miss_count); end
    endtask

    task automatic test_hits;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++; if (ihit !== 1 || iREN !== 0 || imemload !== 32'h2402_0005) begin
                failures++; $display("FAIL repeat_hit ihit=%b iREN=%b imemload=%h exp 1/0/24020005", ihit, iREN, imemload);
            end
        end
        @(negedge clk); imemREN = 0; #1;
        checks++; if (ihit !== 0) begin failures++; $display("FAIL idle_no_req ihit=%b exp=0", ihit); end
        checks++; if (hit_count !== 4) begin failures++; $display("FAIL hit_count got=%0d exp=4", hit_count); end
    endtask

    task automatic test_offset;
        @(negedge clk); imemREN = 1; imemaddr = 32'h43; #1;
        checks++; if (ihit !== 1 || imemload !== 32'h2402_0005) begin
            failures++; $display("FAIL byte_offset ihit=%b imemload=%h exp 1/24020005", ihit, imemload);
        end
    endtask

    task automatic test_conflict;
        do_miss(32'h440, 0, 32'hAAAA_0001);
        do_miss(32'h40, 1, 32'h2402_0005);
        checks++; if (miss_count !== 3) begin failures++; $display("FAIL conflict_miss_count got=%0d exp=3", miss_count); end
    endtask

    task automatic test_flush;
        @(negedge clk); imemREN = 1; imemaddr = 32'h40; iflush = 1; #1;
        checks++; if (ihit !== 0 || iREN !== 0) begin failures++; $display("FAIL flush_cycle ihit=%b iREN=%b exp 0/0", ihit, iREN); end
        do_miss(32'h40, 1, 32'h2402_0005);
        checks++; if (miss_count !== 4) begin failures++; $display("FAIL flush_miss_count got=%0d exp=4", miss_count); end
    endtask

    task automatic test_flush_fill;
        @(negedge clk); imemREN = 1; imemaddr = 32'h84; iwait = 1; #1;
        checks++; if (ihit !== 0) begin failures++; $display("FAIL ff_c0 ihit=%b exp=0", ihit); end
        @(negedge clk); iwait = 0; iload = 32'h1234_5678; iflush = 1; #1;
        checks++; if (iREN !== 1 || iaddr !== 32'h84) begin failures++; $display("FAIL ff_fill iREN=%b iaddr=%h exp 1/84", iREN, iaddr); end
        @(negedge clk); iwait = 1; iflush = 0; #1;
        checks++; if (ihit !== 0 || iREN !== 0) begin failures++; $display("FAIL ff_refetch ihit=%b iREN=%b exp 0/0", ihit, iREN); end
        @(negedge clk); iwait = 0; #1;
        checks++; if (iREN !== 1) begin failures++; $display("FAIL ff_refill iREN=%b exp=1", iREN); end
        @(negedge clk); iwait = 1; #1;
        checks++; if (ihit !== 1 || imemload !== 32'h1234_5678) begin
            failures++; $display("FAIL ff_hit ihit=%b imemload=%h exp 1/12345678", ihit, imemload);
        end
        checks++; if (miss_count !== 6) begin failures++; $display("FAIL ff_miss_count got=%0d exp=6", miss_count); end
    endtask

    task automatic test_rst_miss;
        @(negedge clk); imemREN = 1; imemaddr = 32'hC0; iwait = 1; #1;
        checks++; if (ihit !== 0) begin failures++; $display("FAIL rm_c0 ihit=%b exp=0", ihit); end
        @(negedge clk); #1;
        checks++; if (iREN !== 1 || iaddr !== 32'hC0) begin failures++; $display("FAIL rm_miss1 iREN=%b iaddr=%h exp 1/c0", iREN, iaddr); end
        @(negedge clk); rst = 1; #1;
        @(negedge clk); rst = 0; imemaddr = 32'h40; #1;
        checks++; if (iREN !== 0 || iaddr !== 0) begin failures++; $display("FAIL rm_iren iREN=%b iaddr=%h exp 0/0", iREN, iaddr); end
        checks++; if (hit_count !== 0 || miss_count !== 0) begin
            failures++; $display("FAIL rm_cnt hit=%0d miss=%0d exp 0/0", hit_count, miss_count);
        end
        checks++; if (ihit !== 0) begin failures++; $display("FAIL rm_refetch ihit=%b exp=0", ihit); end
        @(negedge clk); #1;
        checks++; if (iREN !== 1 || iaddr !== 32'h40) begin failures++; $display("FAIL rm_newmiss iREN=%b iaddr=%h exp 1/40", iREN, iaddr); end
    endtask

    initial begin
        test_reset;
        test_miss;
        test_hits;
        test_offset;
        test_conflict;
        test_flush;
        test_flush_fill;
        test_rst_miss;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
